// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit CPU core: fetch/decode/exec/mem phasing,
// memory handshakes, datapath write enables and run/stop/single-step debug control.
module cpu_sequencer #(
    parameter bit          AUTOSTART = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic [2:0]       op_class,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             flags_we,
    output logic             pc_en,
    output logic             pc_jump,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {StHalted, StFetch, StDecode, StExec, StMem} state_e;

    localparam logic [2:0] ClsNop   = 3'd0;
    localparam logic [2:0] ClsAlu   = 3'd1;
    localparam logic [2:0] ClsLoad  = 3'd2;
    localparam logic [2:0] ClsStore = 3'd3;
    localparam logic [2:0] ClsJump  = 3'd4;
    localparam logic [2:0] ClsHalt  = 3'd5;

    state_e     state_q;
    logic [2:0] cls_q;
    logic       step_mode_q;
    logic       stop_pending_q;

    logic cls_illegal;
    logic boundary_halt;

    assign cls_illegal   = cls_q[2] & cls_q[1];
    assign boundary_halt = step_mode_q | stop_pending_q;
    assign halted        = (state_q == StHalted);

    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        flags_we = 1'b0;
        pc_en    = 1'b0;
        pc_jump  = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            StExec: begin
                pc_en    = !cls_illegal;
                rf_we    = (cls_q == ClsAlu);
                flags_we = (cls_q == ClsAlu);
                pc_jump  = (cls_q == ClsJump);
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == ClsStore);
                pc_en    = dmem_ack;
                rf_we    = dmem_ack && (cls_q == ClsLoad);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= AUTOSTART ? StFetch : StHalted;
            cls_q          <= ClsNop;
            step_mode_q    <= 1'b0;
            stop_pending_q <= 1'b0;
            illegal        <= 1'b0;
            instr_count    <= '0;
        end else begin
            if (pc_en) begin
                instr_count <= instr_count + 1'b1;
            end
            if (stop && state_q != StHalted) begin
                stop_pending_q <= 1'b1;
            end
            // Assignments below that enter StHalted also clear stop_pending_q and override the set.
            unique case (state_q)
                StHalted: begin
                    if (start) begin
                        state_q     <= StFetch;
                        step_mode_q <= 1'b0;
                        illegal     <= 1'b0;
                    end else if (step) begin
                        state_q     <= StFetch;
                        step_mode_q <= 1'b1;
                        illegal     <= 1'b0;
                    end
                end
                StFetch: begin
                    if (imem_ack) begin
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    cls_q   <= op_class;
                    state_q <= (op_class == ClsLoad || op_class == ClsStore) ? StMem : StExec;
                end
                StExec: begin
                    if (cls_illegal) begin
                        illegal        <= 1'b1;
                        state_q        <= StHalted;
                        stop_pending_q <= 1'b0;
                    end else if (cls_q == ClsHalt || boundary_halt) begin
                        state_q        <= StHalted;
                        stop_pending_q <= 1'b0;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                StMem: begin
                    if (dmem_ack) begin
                        if (boundary_halt) begin
                            state_q        <= StHalted;
                            stop_pending_q <= 1'b0;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                default: state_q <= StHalted;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a transaction-level model pushes expected retires and
// halts; a negedge monitor pops and compares. A second AUTOSTART=0 instance gets a directed run.
module tb_cpu_sequencer;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start, step, stop, imem_ack, dmem_ack;
    logic [2:0] op_class;
    logic imem_req, ir_load, dmem_req, dmem_we, rf_we, flags_we, pc_en, pc_jump, halted, illegal;
    logic [CW-1:0] instr_count;

    logic start0, step0, stop0, imem_ack0, dmem_ack0;
    logic [2:0] op_class0;
    logic imem_req0, ir_load0, dmem_req0, dmem_we0, rf_we0, flags_we0, pc_en0, pc_jump0;
    logic halted0, illegal0;
    logic [15:0] instr_count0;

    cpu_sequencer #(.AUTOSTART(1'b1), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .stop(stop), .op_class(op_class),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_load(ir_load),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .flags_we(flags_we),
        .pc_en(pc_en), .pc_jump(pc_jump), .halted(halted), .illegal(illegal),
        .instr_count(instr_count)
    );

    cpu_sequencer #(.AUTOSTART(1'b0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .step(step0), .stop(stop0), .op_class(op_class0),
        .imem_ack(imem_ack0), .dmem_ack(dmem_ack0), .imem_req(imem_req0), .ir_load(ir_load0),
        .dmem_req(dmem_req0), .dmem_we(dmem_we0), .rf_we(rf_we0), .flags_we(flags_we0),
        .pc_en(pc_en0), .pc_jump(pc_jump0), .halted(halted0), .illegal(illegal0),
        .instr_count(instr_count0)
    );

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int cyc; bit rf; bit fl; bit jp; bit dwe; bit dreq; int cnt;
    } ret_t;
    typedef struct {
        int cyc; bit ill; int cnt;
    } halt_t;

    ret_t  ret_q[$];
    halt_t halt_q[$];
    ret_t  r;
    halt_t h;
    bit    mon_en = 1'b0;
    bit    halted_prev = 1'b0;
    int    ir_pulses = 0;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (ir_load) ir_pulses <= ir_pulses + 1;
            if (pc_en) begin
                if (ret_q.size() == 0) begin
                    check("unexpected_retire", 1, 0);
                end else begin
                    r = ret_q.pop_front();
                    check("retire_cycle", cyc, r.cyc);
                    check("retire_rf_we", rf_we, r.rf);
                    check("retire_flags_we", flags_we, r.fl);
                    check("retire_pc_jump", pc_jump, r.jp);
                    check("retire_dmem_we", dmem_we, r.dwe);
                    check("retire_dmem_req", dmem_req, r.dreq);
                    check("retire_imem_req", imem_req, 0);
                    check("retire_illegal", illegal, 0);
                    check("retire_count", instr_count, r.cnt);
                end
            end else begin
                check("stray_strobe", {rf_we, flags_we, pc_jump}, 0);
            end
            if (halted && !halted_prev) begin
                if (halt_q.size() == 0) begin
                    check("unexpected_halt", 1, 0);
                end else begin
                    h = halt_q.pop_front();
                    check("halt_cycle", cyc, h.cyc);
                    check("halt_illegal", illegal, h.ill);
                    check("halt_count", instr_count, h.cnt);
                    check("halt_imem_req", imem_req, 0);
                end
            end
            halted_prev <= halted;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int  count_m = 0;
    bit  step_mode_m = 1'b0;
    bit  stop_pend_m = 1'b0;
    int  n_acks = 0;
    int  dir_cls[4] = '{0, 1, 4, 5};

    initial begin
        int c, k, d, a, stop_at, sel, t;
        bit is_mem, halt_now, abort;
        abort = 1'b0;
        {start, step, stop, imem_ack, dmem_ack} = '0;
        op_class = 3'd0;
        {start0, step0, stop0, imem_ack0, dmem_ack0} = '0;
        op_class0 = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_halted", halted, 0);
        check("rst_imem_req", imem_req, 1);
        check("rst_strobes", {ir_load, dmem_req, dmem_we, rf_we, flags_we, pc_en, pc_jump}, 0);
        check("rst_illegal", illegal, 0);
        check("rst_count", instr_count, 0);
        check("rst0_halted", halted0, 1);
        check("rst0_imem_req", imem_req0, 0);
        rst = 1'b0;

        // Directed single-step run on the AUTOSTART=0 instance.
        tick();
        imem_ack0 = 1'b1;
        tick();
        imem_ack0 = 1'b0;
        check("d0_stray_ack_ignored", {halted0, imem_req0}, 2'b10);
        for (int n = 1; n <= 2; n++) begin
            step0 = 1'b1;
            tick();
            step0 = 1'b0;
            check("d0_fetch_req", imem_req0, 1);
            imem_ack0 = 1'b1;
            op_class0 = 3'd1;
            #1;
            check("d0_ir_load", ir_load0, 1);
            tick();
            imem_ack0 = 1'b0;
            tick();
            check("d0_exec", {pc_en0, rf_we0, flags_we0, pc_jump0, dmem_req0, dmem_we0}, 6'b111000);
            tick();
            check("d0_halted_again", halted0, 1);
            check("d0_illegal", illegal0, 0);
            check("d0_count", instr_count0, n);
        end

        mon_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            t = 0;
            while (!imem_req && t < 10) begin
                tick();
                t++;
            end
            check("fetch_req", imem_req, 1);
            if (!imem_req) begin
                abort = 1'b1;
                break;
            end
            k = (i < 4 || $urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                tick();
                check("imem_req_held", {imem_req, ir_load}, 2'b10);
            end
            c       = (i < 4) ? dir_cls[i] : $urandom_range(0, 7);
            is_mem  = (c == 2 || c == 3);
            d       = (is_mem && i >= 4) ? $urandom_range(0, 3) : 0;
            stop_at = (i >= 4 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 1 + d) : -1;
            a       = cyc;

            // Reference model: retire 2+d cycles after the fetch ack; halt one cycle later.
            if (c <= 5) begin
                ret_q.push_back('{a + 2 + d, (c == 1 || c == 2), c == 1, c == 4, c == 3, is_mem,
                                  count_m});
                count_m = (count_m + 1) % (1 << CW);
            end
            if (stop_at > 0) stop_pend_m = 1'b1;
            halt_now = (c >= 5) || step_mode_m || stop_pend_m;
            if (halt_now) begin
                halt_q.push_back('{a + 3 + d, c >= 6, count_m});
                stop_pend_m = 1'b0;
            end

            op_class = c[2:0];
            imem_ack = 1'b1;
            n_acks++;
            tick();
            imem_ack = 1'b0;
            for (int o = 1; o <= 2 + d; o++) begin
                stop     = (o == stop_at);
                dmem_ack = is_mem && (o == 2 + d);
                tick();
            end
            stop     = 1'b0;
            dmem_ack = 1'b0;

            if (halt_now) begin
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) begin
                    imem_ack = ($urandom_range(0, 2) == 0);
                    tick();
                end
                imem_ack = 1'b0;
                sel = $urandom_range(0, 3);
                start = (sel == 0 || sel == 2);
                step  = (sel != 0);
                stop  = $urandom_range(0, 1);
                step_mode_m = !start;
                tick();
                {start, step, stop} = '0;
            end
        end

        repeat (4) tick();
        check("scoreboard_drained", ret_q.size() + halt_q.size(), 0);
        check("ir_load_pulses", ir_pulses, n_acks);

        // Reset asserted while a LOAD waits in MEM.
        if (!abort) begin
            check("final_fetch", imem_req, 1);
            op_class = 3'd2;
            imem_ack = 1'b1;
            tick();
            imem_ack = 1'b0;
            tick();
            check("mem_req_before_rst", {dmem_req, dmem_we, pc_en}, 3'b100);
            mon_en = 1'b0;
            #2;
            rst = 1'b1;
            #1;
            check("midrst_dmem_req", dmem_req, 0);
            check("midrst_imem_req", imem_req, 1);
            check("midrst_pc_en", pc_en, 0);
            check("midrst_count", instr_count, 0);
            check("midrst_halted", halted, 0);
            check("midrst_illegal", illegal, 0);
            check("midrst0_halted", halted0, 1);
            check("midrst0_count", instr_count0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
